regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, at least 1.
REQ-004 SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-005 Ports, as name, direction, width, meaning:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- raddr, in, NRD*AW: read addresses; port k occupies slice k.
- rdata, out, NRD*XLEN: read data per port.
- rbusy, out, NRD: a write to the addressed register is still outstanding.
- wb_en, in, 1: writeback valid.
- wb_addr, in, AW: writeback destination.
- wb_data, in, XLEN: writeback data.
- iss_valid, in, 1: an instruction claims a destination register.
- iss_rd, in, AW: claimed destination.
- iss_ready, out, 1: claim accepted this cycle.
- flush, in, 1: squash all outstanding claims.

Function
REQ-006 Register 0 SHALL always read as 0, SHALL never be written, and SHALL never be pending.
REQ-007 Writeback: on a clk edge with wb_en=1 and wb_addr!=0, regs[wb_addr] SHALL take wb_data and pending[wb_addr] SHALL clear.
REQ-008 Read port k SHALL be combinational with zero-cycle latency.
- raddr_k=0: rdata_k=0.
- Else, if wb_en=1 and wb_addr=raddr_k: rdata_k=wb_data (write-through bypass).
- Else: rdata_k=regs[raddr_k].
REQ-009 rbusy_k SHALL be 1 only when pending[raddr_k]=1 and no same-cycle writeback to raddr_k (wb_en=1, wb_addr=raddr_k) is present.
REQ-010 iss_ready SHALL be 1 only when all of the following hold:
- flush=0;
- iss_rd=0, or pending[iss_rd]=0, or a same-cycle writeback to iss_rd is present.
REQ-011 A claim is accepted when iss_valid=1 and iss_ready=1. On acceptance with iss_rd!=0, pending[iss_rd] SHALL be 1 after the edge.
REQ-012 Claims on register 0 SHALL be accepted and SHALL have no effect.
REQ-013 Same-cycle writeback and accepted claim to the same register: the data write SHALL occur and pending SHALL end at 1 (the set wins).
REQ-014 flush=1 SHALL clear every pending bit on the edge. flush SHALL NOT block writeback, and the register data write SHALL still occur.
REQ-015 A writeback to a non-pending register SHALL write the data and leave pending at 0; this is not an error.
REQ-016 Reads on multiple ports SHALL be independent; duplicate addresses across ports SHALL return identical data.

Reset
REQ-017 While rst_n=0, all registers and all pending bits SHALL be 0 immediately, without waiting for a clock edge.
REQ-018 During reset, every rdata SHALL be 0, every rbusy SHALL be 0, and iss_ready SHALL follow REQ-010.
REQ-019 On reset release, the first edge with rst_n=1 SHALL be a normal operating edge.
REQ-020 Reset asserted mid-operation SHALL discard all outstanding claims and data.

Structure
REQ-021 Package regfile_pkg SHALL hold the default XLEN, NREGS and NRD values and the AW derivation function.
REQ-022 Pending-bit logic (set/clear/flush priority, busy and ready derivation) SHALL be a sub-module, rf_scoreboard. Data storage and bypass SHALL stay in regfile_sb.

Verification
REQ-023 Reset: assert rst_n=0 mid-run with the registers written -> all rdata=0 and rbusy=0 immediately, without waiting for a clock edge.
REQ-024 Bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, raddr0=5 in the same cycle -> rdata0=0xDEADBEEF in that cycle; after the edge it is still 0xDEADBEEF.
REQ-025 Scoreboard sequence, iss_rd=7:
- claim accepted -> rbusy=1 on the next cycle;
- a second claim to 7 -> iss_ready=0;
- writeback to 7 together with the second claim -> iss_ready=1, pending stays 1, data updated.
REQ-026 x0: write 0x1234 to register 0 and claim register 0 -> rdata=0, rbusy=0, iss_ready=1.
REQ-027 Flush: pending on registers 3, 9 and 31; flush=1 together with iss_valid to register 4 -> iss_ready=0, all pending bits clear, register 4 not pending.
REQ-028 Parameter sweep: XLEN=64, NREGS=16, NRD=3 with random claims and writebacks -> a reference model matches rdata, rbusy and iss_ready every cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NRD_DEFAULT   = 2;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback and issue-claim signals of the scoreboarded register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = NRD_DEFAULT
);
    localparam int AW = addr_width(NREGS);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;

    modport master (
        output raddr, wb_en, wb_addr, wb_data, iss_valid, iss_rd, flush,
        input  rdata, rbusy, iss_ready
    );

    modport slave (
        input  raddr, wb_en, wb_addr, wb_data, iss_valid, iss_rd, flush,
        output rdata, rbusy, iss_ready
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: claim sets, writeback clears, flush clears all.
// Derives per-port busy flags and the issue-ready handshake.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = NRD_DEFAULT,
    localparam int AW   = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NRD-1:0]    rbusy,
    output logic              iss_ready
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             accept;

    // A same-cycle writeback to the claimed register frees it in time for the new claim.
    assign iss_ready = !flush &&
                       ((iss_rd == '0) || !pending[iss_rd] || (wb_en && (wb_addr == iss_rd)));
    assign accept    = iss_valid && iss_ready;

    // NOTE: the default comes first so every path assigns pending_next and no latch is inferred.
    always_comb begin
        pending_next = pending;
        if (wb_en)  pending_next[wb_addr] = 1'b0;
        if (accept) pending_next[iss_rd]  = 1'b1;
        if (flush)  pending_next          = '0;
        pending_next[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

    always_comb begin
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            rbusy[k] = pending[raddr[k*AW +: AW]] &&
                       !(wb_en && (wb_addr == raddr[k*AW +: AW]));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a pending-write scoreboard.
// Register 0 is hardwired to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = NRD_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    localparam int AW = addr_width(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wb_write;

    assign wb_write = bus.wb_en && (bus.wb_addr != '0);

    // NOTE: the storage array is reset because reset must clear register contents, not just control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        bus.rdata = '0;
        for (int k = 0; k < NRD; k++) begin
            if (bus.raddr[k*AW +: AW] == '0)
                bus.rdata[k*XLEN +: XLEN] = '0;
            else if (bus.wb_en && (bus.wb_addr == bus.raddr[k*AW +: AW]))
                bus.rdata[k*XLEN +: XLEN] = bus.wb_data;
            else
                bus.rdata[k*XLEN +: XLEN] = regs[bus.raddr[k*AW +: AW]];
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr     (bus.raddr),
        .wb_en     (bus.wb_en),
        .wb_addr   (bus.wb_addr),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .flush     (bus.flush),
        .rbusy     (bus.rbusy),
        .iss_ready (bus.iss_ready)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table on the default configuration, a reset sequence,
// and a randomized reference-model sweep on a 64-bit/16-reg/3-port instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
    regfile_sb_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_b ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        iss_valid;
        logic [4:0]  iss_rd;
        logic        flush;
        logic [31:0] rd0, rd1;
        logic [1:0]  busy;
        logic        ready;
    } vec_t;

    function automatic vec_t mk(
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic wb_en, input logic [4:0] wb_addr, input logic [31:0] wb_data,
        input logic iss_valid, input logic [4:0] iss_rd, input logic flush,
        input logic [31:0] rd0, input logic [31:0] rd1,
        input logic [1:0] busy, input logic ready);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1;
        v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.iss_valid = iss_valid; v.iss_rd = iss_rd; v.flush = flush;
        v.rd0 = rd0; v.rd1 = rd1; v.busy = busy; v.ready = ready;
        return v;
    endfunction

    typedef struct {
        logic [191:0] rdata;
        logic [2:0]   rbusy;
        logic         ready;
    } exp_t;

    exp_t exp_q[$];

    vec_t        vecs [21];
    logic [63:0] m_regs [16];
    logic [15:0] m_pend;

    task automatic drive_a(input vec_t v);
        bus_a.raddr     = {v.ra1, v.ra0};
        bus_a.wb_en     = v.wb_en;
        bus_a.wb_addr   = v.wb_addr;
        bus_a.wb_data   = v.wb_data;
        bus_a.iss_valid = v.iss_valid;
        bus_a.iss_rd    = v.iss_rd;
        bus_a.flush     = v.flush;
    endtask

    initial begin
        // Each record is one cycle: inputs, then outputs expected before that cycle's edge.
        vecs[0]  = mk(5, 0,  0, 0, 0,            0, 0, 0,  0, 0,                     2'b00, 1);
        vecs[1]  = mk(5, 5,  1, 5, 32'hDEADBEEF, 0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1);
        vecs[2]  = mk(5, 6,  0, 0, 0,            0, 0, 0,  32'hDEADBEEF, 0,            2'b00, 1);
        vecs[3]  = mk(0, 0,  1, 0, 32'h1234,     1, 0, 0,  0, 0,                     2'b00, 1);
        vecs[4]  = mk(0, 5,  0, 0, 0,            0, 0, 0,  0, 32'hDEADBEEF,            2'b00, 1);
        vecs[5]  = mk(7, 5,  0, 0, 0,            1, 7, 0,  0, 32'hDEADBEEF,            2'b00, 1);
        vecs[6]  = mk(7, 5,  0, 0, 0,            1, 7, 0,  0, 32'hDEADBEEF,            2'b01, 0);
        vecs[7]  = mk(7, 5,  1, 7, 32'hA5A50007, 1, 7, 0,  32'hA5A50007, 32'hDEADBEEF, 2'b00, 1);
        vecs[8]  = mk(7, 7,  0, 0, 0,            0, 0, 0,  32'hA5A50007, 32'hA5A50007, 2'b11, 1);
        vecs[9]  = mk(7, 0,  1, 7, 32'h77,       0, 0, 0,  32'h77, 0,                2'b00, 1);
        vecs[10] = mk(7, 0,  0, 0, 0,            0, 0, 0,  32'h77, 0,                2'b00, 1);
        vecs[11] = mk(3, 0,  0, 0, 0,            1, 3, 0,  0, 0,                     2'b00, 1);
        vecs[12] = mk(3, 0,  0, 0, 0,            1, 9, 0,  0, 0,                     2'b01, 1);
        vecs[13] = mk(9, 31, 0, 0, 0,            1, 31, 0, 0, 0,                     2'b01, 1);
        vecs[14] = mk(3, 31, 1, 9, 32'h0909,     1, 4, 1,  0, 0,                     2'b11, 0);
        vecs[15] = mk(4, 3,  0, 0, 0,            0, 4, 0,  0, 0,                     2'b00, 1);
        vecs[16] = mk(9, 31, 0, 0, 0,            0, 0, 0,  32'h0909, 0,              2'b00, 1);
        vecs[17] = mk(12, 9, 1, 12, 32'hC,       0, 0, 0,  32'hC, 32'h0909,          2'b00, 1);
        vecs[18] = mk(12, 0, 0, 0, 0,            0, 0, 0,  32'hC, 0,                 2'b00, 1);
        vecs[19] = mk(20, 0, 0, 0, 0,            1, 20, 0, 0, 0,                     2'b00, 1);
        vecs[20] = mk(20, 21, 1, 21, 32'h21,     1, 20, 0, 0, 32'h21,                2'b01, 0);

        rst_n = 1'b0;
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        bus_b.raddr = '0; bus_b.wb_en = 1'b0; bus_b.wb_addr = '0; bus_b.wb_data = '0;
        bus_b.iss_valid = 1'b0; bus_b.iss_rd = '0; bus_b.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            drive_a(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d rdata0", i), 64'(bus_a.rdata[31:0]),  64'(vecs[i].rd0));
            check($sformatf("v%0d rdata1", i), 64'(bus_a.rdata[63:32]), 64'(vecs[i].rd1));
            check($sformatf("v%0d rbusy", i),  64'(bus_a.rbusy),        64'(vecs[i].busy));
            check($sformatf("v%0d iss_ready", i), 64'(bus_a.iss_ready), 64'(vecs[i].ready));
            @(posedge clk); #1;
        end

        // Mid-run asynchronous reset: reg 5 written, reg 20 pending.
        drive_a(mk(5, 20, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        #1;
        check("pre_rst rdata0", 64'(bus_a.rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
        check("pre_rst rbusy",  64'(bus_a.rbusy), 64'd2);
        rst_n = 1'b0;
        #1;
        check("rst rdata0", 64'(bus_a.rdata[31:0]),  64'd0);
        check("rst rdata1", 64'(bus_a.rdata[63:32]), 64'd0);
        check("rst rbusy",  64'(bus_a.rbusy), 64'd0);
        check("rst iss_ready", 64'(bus_a.iss_ready), 64'd1);
        bus_a.flush = 1'b1;
        #1;
        check("rst flush iss_ready", 64'(bus_a.iss_ready), 64'd0);
        bus_a.flush = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        drive_a(mk(7, 20, 1, 5, 32'h55, 0, 0, 0, 0, 0, 2'b00, 0));
        @(posedge clk); #1;
        bus_a.wb_en = 1'b0;
        bus_a.raddr = {5'd20, 5'd5};
        #1;
        check("post_rst rdata0", 64'(bus_a.rdata[31:0]), 64'h55);
        check("post_rst rbusy",  64'(bus_a.rbusy), 64'd0);

        // Randomized sweep of the wide configuration against a reference model.
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_pend = '0;
        for (int c = 0; c < 400; c++) begin
            logic        s_wb_en, s_iv, s_flush, s_ready;
            logic [3:0]  s_wb_addr, s_ird;
            logic [63:0] s_wb_data;
            logic [3:0]  s_ra [3];
            exp_t        e, got;

            s_wb_en   = 1'($urandom_range(0, 1));
            s_wb_addr = 4'($urandom_range(0, 15));
            s_wb_data = {$urandom, $urandom};
            s_iv      = 1'($urandom_range(0, 2) != 0);
            s_ird     = 4'($urandom_range(0, 15));
            s_flush   = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < 3; k++) s_ra[k] = 4'($urandom_range(0, 15));

            s_ready = !s_flush && ((s_ird == 0) || !m_pend[s_ird] ||
                                   (s_wb_en && (s_wb_addr == s_ird)));
            e.ready = s_ready;
            for (int k = 0; k < 3; k++) begin
                if (s_ra[k] == 0)                          e.rdata[k*64 +: 64] = '0;
                else if (s_wb_en && (s_wb_addr == s_ra[k])) e.rdata[k*64 +: 64] = s_wb_data;
                else                                       e.rdata[k*64 +: 64] = m_regs[s_ra[k]];
                e.rbusy[k] = m_pend[s_ra[k]] && !(s_wb_en && (s_wb_addr == s_ra[k]));
            end
            exp_q.push_back(e);

            bus_b.raddr     = {s_ra[2], s_ra[1], s_ra[0]};
            bus_b.wb_en     = s_wb_en;
            bus_b.wb_addr   = s_wb_addr;
            bus_b.wb_data   = s_wb_data;
            bus_b.iss_valid = s_iv;
            bus_b.iss_rd    = s_ird;
            bus_b.flush     = s_flush;

            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("c%0d queue", c), 64'd0, 64'd1);
            end else begin
                got = exp_q.pop_front();
                for (int k = 0; k < 3; k++)
                    check($sformatf("c%0d rdata%0d", c, k), bus_b.rdata[k*64 +: 64], got.rdata[k*64 +: 64]);
                check($sformatf("c%0d rbusy", c), 64'(bus_b.rbusy), 64'(got.rbusy));
                check($sformatf("c%0d iss_ready", c), 64'(bus_b.iss_ready), 64'(got.ready));
            end

            @(posedge clk);
            if (s_wb_en && (s_wb_addr != 0)) m_regs[s_wb_addr] = s_wb_data;
            if (s_wb_en) m_pend[s_wb_addr] = 1'b0;
            if (s_iv && s_ready && (s_ird != 0)) m_pend[s_ird] = 1'b1;
            if (s_flush) m_pend = '0;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
